addsub_inverse_serial: RTL and testbench

//  Bit-serial inverse of the 4-bit add/sub datapath: from a result s, operand b and the sign

---
 rtl/addsub_inverse_serial.sv | 128 ++++++++++++
 tb/tb_addsub_inverse_serial.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_inverse_serial.sv
// addsub_inverse_serial: bit-serial inverse of a WIDTH-bit add/sub datapath.
// Given a result s, operand b and the sign mode, recovers operand a (mod 2^W)
// one bit per clock through a single full-adder slice and a carry/borrow flop,
// and flags results that no W-bit operand a could have produced.
// Optional feature macro: ADDSUB_INV_B2B_EN (back-to-back accept from DONE).
module addsub_inverse_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [WIDTH:0]   s_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             err_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   s_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] a_sh;
  logic             sign_r;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_step;
  logic             s_bit;
  logic             b_bit;
  logic             a_bit;
  logic             cy_next;
  logic             err_final;

  // Next-state and handshake decode; ready/valid come straight from the state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef ADDSUB_INV_B2B_EN
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
`else
        if (out_ready) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH));

  // One full-adder slice: subtract-with-borrow for sign=0, add-with-carry for sign=1.
  always_comb begin
    s_bit     = s_sh[0];
    b_bit     = b_sh[0];
    a_bit     = s_bit ^ b_bit ^ cy;
    cy_next   = 1'b0;
    err_final = 1'b0;
    if (sign_r) begin
      cy_next   = (s_bit & b_bit) | (s_bit & cy) | (b_bit & cy);
      err_final = (cy == s_bit);
    end else begin
      cy_next   = (~s_bit & b_bit) | (~(s_bit ^ b_bit) & cy);
      err_final = cy_next | a_bit;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: load on accept, shift one bit per RUN step, publish on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_sh    <= '0;
      b_sh    <= '0;
      a_sh    <= '0;
      sign_r  <= 1'b0;
      cy      <= 1'b0;
      cnt     <= '0;
      a_out   <= '0;
      err_out <= 1'b0;
    end else if (accept) begin
      s_sh   <= s_in;
      b_sh   <= b_in;
      sign_r <= sign_in;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      s_sh <= {1'b0, s_sh[WIDTH:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      cy   <= cy_next;
      if (last_step) begin
        a_out   <= a_sh;
        err_out <= err_final;
      end else begin
        a_sh <= {a_bit, a_sh[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_addsub_inverse_serial.sv
// tb_addsub_inverse_serial: randomized and directed bench for addsub_inverse_serial
// against an arithmetic reference model of the inverse add/sub.
module tb_addsub_inverse_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sign_in = 1'b0;
  logic [4:0] s_in = '0;
  logic [3:0] b_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] a_out;
  logic       err_out;

  int compare_count = 0;
  int mismatch_count = 0;

  addsub_inverse_serial #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .s_in      (s_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .err_out   (err_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: sign=0 means a = s - b must fit in W bits; sign=1 means a = d + b,
  // and the stored a>=b flag must match whether that sum wrapped.
  task automatic refModel(input logic sg, input logic [4:0] s, input logic [3:0] b,
                          output int a_exp, output int err_exp);
    int full;
    if (!sg) begin
      full    = int'(s) - int'(b);
      a_exp   = (full + 32) % 16;
      err_exp = (full < 0 || full >= 16) ? 1 : 0;
    end else begin
      full    = int'(s[3:0]) + int'(b);
      a_exp   = full % 16;
      err_exp = ((full >= 16) == s[4]) ? 1 : 0;
    end
  endtask

  // Wait for out_valid with a bound; returns edges seen since the last accept.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic sg, input logic [4:0] s, input logic [3:0] b,
                               input int hold);
    int a_exp, err_exp, cycles;
    refModel(sg, s, b, a_exp, err_exp);
    checkOutput("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    sign_in  = sg;
    s_in     = s;
    b_in     = b;
    tick();
    in_valid = 1'b0;
    s_in     = 5'($urandom);
    b_in     = 4'($urandom);
    sign_in  = 1'($urandom);
    waitValid(cycles);
    checkOutput("latency", cycles, 5);
    checkOutput("a_out", int'(a_out), a_exp);
    checkOutput("err_out", int'(err_out), err_exp);
    checkOutput("in_ready_done", int'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      tick();
      in_valid = 1'b0;
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_a", int'(a_out), a_exp);
      checkOutput("hold_err", int'(err_out), err_exp);
      checkOutput("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_valid", int'(out_valid), 0);
    checkOutput("release_in_ready", int'(in_ready), 1);
  endtask

  // Main sequence: reset, directed cases, mid-run reset, optional back-to-back, sweeps.
  initial begin
    int a_exp, err_exp, cycles;
    logic [4:0] s_fwd;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_a_out", int'(a_out), 0);
    checkOutput("rst_err", int'(err_out), 0);

    applyStimulus(1'b0, 5'd11, 4'd3, 0);
    applyStimulus(1'b0, 5'd2, 4'd5, 0);
    applyStimulus(1'b0, 5'd31, 4'd0, 0);
    applyStimulus(1'b1, {1'b1, 4'd2}, 4'd7, 0);
    applyStimulus(1'b1, {1'b1, 4'd14}, 4'd5, 10);

    // Reset in the middle of RUN drops the request.
    in_valid = 1'b1;
    sign_in  = 1'b0;
    s_in     = 5'd20;
    b_in     = 4'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_a_out", int'(a_out), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("midrst_no_output", int'(out_valid), 0);
    end

`ifdef ADDSUB_INV_B2B_EN
    // Back-to-back: handshake and new accept on the same edge.
    in_valid = 1'b1;
    sign_in  = 1'b0;
    s_in     = 5'd9;
    b_in     = 4'd4;
    tick();
    in_valid = 1'b0;
    waitValid(cycles);
    checkOutput("b2b_first_latency", cycles, 5);
    checkOutput("b2b_first_a", int'(a_out), 5);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sign_in   = 1'b1;
    s_in      = {1'b0, 4'd12};
    b_in      = 4'd6;
    checkOutput("b2b_in_ready", int'(in_ready), 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_valid_drop", int'(out_valid), 0);
    waitValid(cycles);
    checkOutput("b2b_second_gap", cycles + 1, 6);
    refModel(1'b1, {1'b0, 4'd12}, 4'd6, a_exp, err_exp);
    checkOutput("b2b_second_a", int'(a_out), a_exp);
    checkOutput("b2b_second_err", int'(err_out), err_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("b2b_idle", int'(in_ready), 1);
`endif

    // Forward-model sweep: every consistent (a, b, sign) must round-trip with err=0.
    for (int sg = 0; sg < 2; sg++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if (sg == 0) s_fwd = 5'(a + b);
          else         s_fwd = {(a >= b) ? 1'b1 : 1'b0, 4'((a - b + 16) % 16)};
          refModel(1'(sg), s_fwd, 4'(b), a_exp, err_exp);
          checkOutput("fwd_model_err", err_exp, 0);
          checkOutput("fwd_model_a", a_exp, a);
          applyStimulus(1'(sg), s_fwd, 4'(b), 0);
        end
      end
    end

    // Random results, including inconsistent ones, with random output back-pressure.
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom), 5'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
